mcu_queue_buffer: RTL and testbench
===================================

MCU_QUEUE_BUFFER -- requirements
Module: mcu_queue_buffer

Interface
REQ-001 Parameter DEPTH, default 256: frame capacity in bytes, power of two.
REQ-002 Parameter ADDR_W, default 8: log2(DEPTH).
REQ-003 i_master_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 i_reset  in  1  reset, asynchronous, active-high.
REQ-005 i_data  in  8  received byte from UART.
REQ-006 i_data_start  in  1  one-cycle pulse marking the start of a frame.
REQ-007 i_data_valid  in  1  one-cycle pulse qualifying i_data.
REQ-008 i_data_end  in  1  one-cycle pulse marking the end of a frame.
REQ-009 i_queue_locked  in  1  high while the system controller forbids accepting a new frame.
REQ-010 i_replay_start  in  1  one-cycle pulse requesting replay of the stored frame to the renderer.
REQ-011 i_queue_ready  in  1  renderer can accept a byte this cycle.
REQ-012 o_queue_start  out  1  one-cycle pulse that precedes the replayed bytes.
REQ-013 o_queue_data  out  8  replayed byte.
REQ-014 o_queue_data_valid  out  1  qualifies o_queue_data.
REQ-015 o_replay_done  out  1  one-cycle pulse after the last replayed byte.
REQ-016 o_frame_ready  out  1  a complete frame is stored.
REQ-017 o_frame_length  out  ADDR_W+1  byte count of the stored frame, 0..DEPTH.
REQ-018 o_overflow  out  1  sticky: the last frame exceeded DEPTH.

Function
REQ-019 The FSM SHALL have states IDLE, RECEIVE, DROP, STORED, REPLAY.
REQ-020 IDLE/STORED + i_data_start, i_queue_locked=0 -> RECEIVE; write pointer := 0; o_frame_ready := 0; o_overflow := 0.
REQ-021 IDLE/STORED + i_data_start, i_queue_locked=1 -> DROP; the stored frame and its flags stay unchanged.
REQ-022 RECEIVE + i_data_valid SHALL write i_data at the write pointer and increment it in the same cycle.
REQ-023 RECEIVE + i_data_valid with write pointer = DEPTH -> DROP; o_overflow := 1; byte discarded.
REQ-024 RECEIVE + i_data_end -> STORED; o_frame_length := write pointer; o_frame_ready := 1 on the next cycle.
REQ-025 If i_data_valid and i_data_end coincide in RECEIVE, the byte SHALL be written first and counted in o_frame_length.
REQ-026 RECEIVE + i_data_start SHALL restart the frame: write pointer := 0; earlier bytes discarded.
REQ-027 DROP SHALL ignore data; i_data_end -> IDLE (o_frame_ready=0); i_data_start in DROP re-evaluates per REQ-020/021.
REQ-028 STORED + i_replay_start -> REPLAY; o_queue_start asserts the next cycle; read pointer := 0.
REQ-029 i_replay_start in any other state SHALL be ignored.
REQ-030 REPLAY SHALL issue one RAM read per cycle while i_queue_ready=1 and read pointer < o_frame_length.
REQ-031 Read latency: o_queue_data_valid asserts exactly one cycle after its read is issued; data is never issued while i_queue_ready=0.
REQ-032 After the last valid byte, o_replay_done SHALL pulse on the next cycle and the FSM returns to STORED; the frame may be replayed again.
REQ-033 Zero-length frame: replay emits o_queue_start, then o_replay_done one cycle later, with no valid data.
REQ-034 In REPLAY, i_data_start/valid/end SHALL be ignored; the frame is not overwritten.
REQ-035 i_data_end outside RECEIVE/DROP SHALL be ignored.

Reset
REQ-036 Asserting i_reset SHALL force IDLE and set all outputs and both pointers to 0 asynchronously, including mid-receive or mid-replay.
REQ-037 RAM contents need no reset; the stored frame is invalid after reset.

Structure
REQ-038 Package mcu_queue_pkg SHALL hold the FSM state enum, DEPTH default and ADDR_W default.
REQ-039 Storage SHALL be a sub-module mcu_queue_ram: simple dual-port, DEPTH x 8, registered read, inferable as block RAM.

Verification
REQ-040 Start, bytes 0x11,0x22,0x33, end -> o_frame_length=3, o_frame_ready=1; replay -> start, then 0x11,0x22,0x33 valid, then done.
REQ-041 Replay with i_queue_ready toggling 1,0,0,1,1 -> bytes in order, none duplicated or lost, done after the third byte.
REQ-042 Start with i_queue_locked=1, then 5 bytes -> previous frame and length unchanged; o_frame_ready remains as before.
REQ-043 257 bytes with DEPTH=256 -> o_overflow=1, o_frame_ready=0 after end; i_replay_start ignored.
REQ-044 i_reset asserted mid-replay at byte 2 -> outputs 0 immediately; FSM in IDLE; later replay pulse ignored.
REQ-045 Start immediately followed by end -> length 0; replay gives start, done one cycle later, no data valid.

Source files
------------

// File: rtl/mcu_queue_pkg.sv
// Shared types and defaults for the UART frame queue buffer.
package mcu_queue_pkg;

  localparam int unsigned DEPTH_DEF  = 256;
  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RECEIVE = 3'd1,
    ST_DROP    = 3'd2,
    ST_STORED  = 3'd3,
    ST_REPLAY  = 3'd4
  } state_e;

endpackage

// File: rtl/mcu_queue_ram.sv
// Simple dual-port frame storage with registered read; contents are never reset.
module mcu_queue_ram
  import mcu_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      o_rd_data <= r_mem[i_rd_addr];
    end
  end

endmodule

// File: rtl/mcu_queue_buffer.sv
// Captures one UART frame into RAM and replays it to the renderer with
// backpressure; a locked or oversized frame is dropped without touching storage.
module mcu_queue_buffer
  import mcu_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              i_master_clk,
  input  logic              i_reset,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_data_start,
  input  logic              i_data_valid,
  input  logic              i_data_end,
  input  logic              i_queue_locked,
  input  logic              i_replay_start,
  input  logic              i_queue_ready,
  output logic              o_queue_start,
  output logic [DATA_W-1:0] o_queue_data,
  output logic              o_queue_data_valid,
  output logic              o_replay_done,
  output logic              o_frame_ready,
  output logic [ADDR_W:0]   o_frame_length,
  output logic              o_overflow
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  state_e            r_state;
  logic [CNT_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_frame_length;
  logic              r_frame_ready;
  logic              r_overflow;
  logic              r_queue_start;
  logic              r_queue_valid;
  logic              r_replay_done;

  logic [CNT_W-1:0]  w_wr_base;
  logic [CNT_W-1:0]  w_wr_next;
  logic              w_wr_full;
  logic              w_wr_en;
  logic              w_rd_en;
  logic [DATA_W-1:0] w_rd_data;

  // A start inside RECEIVE rebases the write pointer so a coincident byte lands at 0.
  always_comb begin
    w_wr_base = i_data_start ? '0 : r_wr_ptr;
    w_wr_full = (w_wr_base == CNT_W'(DEPTH));
    w_wr_en   = (r_state == ST_RECEIVE) && i_data_valid && !w_wr_full;
    w_wr_next = w_wr_base + CNT_W'(w_wr_en);
    w_rd_en   = (r_state == ST_REPLAY) && i_queue_ready && (r_rd_ptr < r_frame_length);
  end

  mcu_queue_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk     (i_master_clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_base[ADDR_W-1:0]),
    .i_wr_data (i_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge i_master_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= ST_IDLE;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_frame_length <= '0;
      r_frame_ready  <= 1'b0;
      r_overflow     <= 1'b0;
      r_queue_start  <= 1'b0;
      r_queue_valid  <= 1'b0;
      r_replay_done  <= 1'b0;
    end else begin
      r_queue_start <= 1'b0;
      r_replay_done <= 1'b0;
      r_queue_valid <= w_rd_en;
      case (r_state)
        ST_IDLE, ST_STORED, ST_DROP: begin
          if (i_data_start) begin
            if (i_queue_locked) begin
              r_state <= ST_DROP;
            end else begin
              r_state       <= ST_RECEIVE;
              r_wr_ptr      <= '0;
              r_frame_ready <= 1'b0;
              r_overflow    <= 1'b0;
            end
          end else if (r_state == ST_DROP) begin
            // A locked drop from STORED keeps its frame; an overflow drop has none.
            if (i_data_end) begin
              r_state <= r_frame_ready ? ST_STORED : ST_IDLE;
            end
          end else if ((r_state == ST_STORED) && i_replay_start) begin
            r_state       <= ST_REPLAY;
            r_rd_ptr      <= '0;
            r_queue_start <= 1'b1;
          end
        end
        ST_RECEIVE: begin
          if (i_data_valid && w_wr_full) begin
            r_overflow <= 1'b1;
            r_state    <= i_data_end ? ST_IDLE : ST_DROP;
          end else begin
            r_wr_ptr <= w_wr_next;
            if (i_data_end) begin
              r_state        <= ST_STORED;
              r_frame_length <= w_wr_next;
              r_frame_ready  <= 1'b1;
            end
          end
        end
        ST_REPLAY: begin
          if (w_rd_en) begin
            r_rd_ptr <= r_rd_ptr + CNT_W'(1);
          end else if (r_rd_ptr == r_frame_length) begin
            r_replay_done <= 1'b1;
            r_state       <= ST_STORED;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // RAM output register is not reset, so it is qualified by the registered valid.
  assign o_queue_data       = w_rd_data & {DATA_W{r_queue_valid}};
  assign o_queue_data_valid = r_queue_valid;
  assign o_queue_start      = r_queue_start;
  assign o_replay_done      = r_replay_done;
  assign o_frame_ready      = r_frame_ready;
  assign o_frame_length     = r_frame_length;
  assign o_overflow         = r_overflow;

endmodule

// File: tb/tb_mcu_queue_buffer.sv
// Directed self-checking bench for mcu_queue_buffer (DEPTH=256).
module tb_mcu_queue_buffer;
  import mcu_queue_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] i_data;
  logic       i_data_start, i_data_valid, i_data_end;
  logic       i_queue_locked, i_replay_start, i_queue_ready;
  logic       o_queue_start, o_queue_data_valid, o_replay_done;
  logic       o_frame_ready, o_overflow;
  logic [7:0] o_queue_data;
  logic [8:0] o_frame_length;

  int checks = 0;
  int errors = 0;

  mcu_queue_buffer #(.DEPTH(256), .ADDR_W(8)) dut (
    .i_master_clk       (clk),
    .i_reset            (rst),
    .i_data             (i_data),
    .i_data_start       (i_data_start),
    .i_data_valid       (i_data_valid),
    .i_data_end         (i_data_end),
    .i_queue_locked     (i_queue_locked),
    .i_replay_start     (i_replay_start),
    .i_queue_ready      (i_queue_ready),
    .o_queue_start      (o_queue_start),
    .o_queue_data       (o_queue_data),
    .o_queue_data_valid (o_queue_data_valid),
    .o_replay_done      (o_replay_done),
    .o_frame_ready      (o_frame_ready),
    .o_frame_length     (o_frame_length),
    .o_overflow         (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    i_data_start = 1'b1; tick(); i_data_start = 1'b0;
  endtask

  task automatic pulse_end();
    i_data_end = 1'b1; tick(); i_data_end = 1'b0;
  endtask

  task automatic pulse_replay();
    i_replay_start = 1'b1; tick(); i_replay_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_data = b; i_data_valid = 1'b1; tick(); i_data_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({o_queue_start, o_queue_data_valid, o_replay_done, o_frame_ready, o_overflow} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000",
        {o_queue_start, o_queue_data_valid, o_replay_done, o_frame_ready, o_overflow});
    end
    checks++;
    if (o_frame_length !== 9'd0) begin
      errors++; $display("FAIL reset_length: got %0d expected 0", o_frame_length);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (dut.r_state !== ST_IDLE || o_frame_ready !== 1'b0) begin
      errors++; $display("FAIL reset_idle: state %0d ready %b expected IDLE/0", dut.r_state, o_frame_ready);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
    pulse_start();
    for (int i = 0; i < 3; i++) send_byte(exp_b[i]);
    checks++;
    if (o_frame_ready !== 1'b0) begin
      errors++; $display("FAIL basic_ready_early: got %b expected 0", o_frame_ready);
    end
    pulse_end();
    checks++;
    if (o_frame_length !== 9'd3 || o_frame_ready !== 1'b1) begin
      errors++; $display("FAIL basic_stored: len %0d ready %b expected 3/1", o_frame_length, o_frame_ready);
    end
    i_queue_ready = 1'b1;
    pulse_replay();
    checks++;
    if (o_queue_start !== 1'b1 || o_queue_data_valid !== 1'b0) begin
      errors++; $display("FAIL basic_qstart: start %b valid %b expected 1/0", o_queue_start, o_queue_data_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (o_queue_data_valid !== 1'b1 || o_queue_data !== exp_b[i] || o_queue_start !== 1'b0) begin
        errors++; $display("FAIL basic_byte%0d: valid %b data %h expected 1/%h", i,
          o_queue_data_valid, o_queue_data, exp_b[i]);
      end
    end
    tick();
    checks++;
    if (o_replay_done !== 1'b1 || o_queue_data_valid !== 1'b0) begin
      errors++; $display("FAIL basic_done: done %b valid %b expected 1/0", o_replay_done, o_queue_data_valid);
    end
    tick();
    checks++;
    if (o_replay_done !== 1'b0) begin
      errors++; $display("FAIL basic_done_pulse: got %b expected 0", o_replay_done);
    end
  endtask

  // Replay of 11,22,33 with ready 1,0,0,1,1,1; a stray write attempt during a stall.
  task automatic test_ready_toggle();
    logic       rdy   [6];
    logic       exp_v [6];
    logic       exp_d [6];
    logic [7:0] exp_b [6];
    rdy   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_d = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_b = '{8'h11, 8'h00, 8'h00, 8'h22, 8'h33, 8'h00};
    i_queue_ready = 1'b0;
    pulse_replay();
    checks++;
    if (o_queue_start !== 1'b1) begin
      errors++; $display("FAIL toggle_qstart: got %b expected 1", o_queue_start);
    end
    for (int k = 0; k < 6; k++) begin
      i_queue_ready = rdy[k];
      if (k == 2) begin
        i_data_start = 1'b1; i_data_valid = 1'b1; i_data = 8'hEE;
      end
      tick();
      i_data_start = 1'b0; i_data_valid = 1'b0;
      checks++;
      if (o_queue_data_valid !== exp_v[k] || o_replay_done !== exp_d[k] ||
          (exp_v[k] && o_queue_data !== exp_b[k])) begin
        errors++; $display("FAIL toggle_cycle%0d: valid %b data %h done %b expected %b/%h/%b", k,
          o_queue_data_valid, o_queue_data, o_replay_done, exp_v[k], exp_b[k], exp_d[k]);
      end
    end
    checks++;
    if (o_frame_ready !== 1'b1 || o_frame_length !== 9'd3) begin
      errors++; $display("FAIL toggle_frame_kept: ready %b len %0d expected 1/3", o_frame_ready, o_frame_length);
    end
  endtask

  task automatic test_locked();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
    i_queue_locked = 1'b1;
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i));
    pulse_end();
    i_queue_locked = 1'b0;
    checks++;
    if (o_frame_ready !== 1'b1 || o_frame_length !== 9'd3 || o_overflow !== 1'b0) begin
      errors++; $display("FAIL locked_flags: ready %b len %0d ovf %b expected 1/3/0",
        o_frame_ready, o_frame_length, o_overflow);
    end
    i_queue_ready = 1'b1;
    pulse_replay();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (o_queue_data_valid !== 1'b1 || o_queue_data !== exp_b[i]) begin
        errors++; $display("FAIL locked_byte%0d: valid %b data %h expected 1/%h", i,
          o_queue_data_valid, o_queue_data, exp_b[i]);
      end
    end
    tick();
    checks++;
    if (o_replay_done !== 1'b1) begin
      errors++; $display("FAIL locked_done: got %b expected 1", o_replay_done);
    end
  endtask

  task automatic test_reset_mid_replay();
    i_queue_ready = 1'b1;
    pulse_replay();
    tick(); tick();
    checks++;
    if (o_queue_data_valid !== 1'b1 || o_queue_data !== 8'h22) begin
      errors++; $display("FAIL midrst_byte2: valid %b data %h expected 1/22", o_queue_data_valid, o_queue_data);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({o_queue_start, o_queue_data_valid, o_replay_done, o_frame_ready, o_overflow} !== 5'b0 ||
        o_queue_data !== 8'h00 || o_frame_length !== 9'd0) begin
      errors++; $display("FAIL midrst_outputs: flags %b data %h len %0d expected 0",
        {o_queue_start, o_queue_data_valid, o_replay_done, o_frame_ready, o_overflow},
        o_queue_data, o_frame_length);
    end
    checks++;
    if (dut.r_state !== ST_IDLE) begin
      errors++; $display("FAIL midrst_state: got %0d expected %0d", dut.r_state, ST_IDLE);
    end
    rst = 1'b0;
    tick();
    pulse_replay();
    checks++;
    if (o_queue_start !== 1'b0) begin
      errors++; $display("FAIL midrst_replay_ignored: start %b expected 0", o_queue_start);
    end
    tick();
    checks++;
    if (o_queue_data_valid !== 1'b0 || o_replay_done !== 1'b0) begin
      errors++; $display("FAIL midrst_no_data: valid %b done %b expected 0/0", o_queue_data_valid, o_replay_done);
    end
  endtask

  task automatic test_zero_length();
    pulse_start();
    pulse_end();
    checks++;
    if (o_frame_length !== 9'd0 || o_frame_ready !== 1'b1) begin
      errors++; $display("FAIL zero_stored: len %0d ready %b expected 0/1", o_frame_length, o_frame_ready);
    end
    i_queue_ready = 1'b1;
    pulse_replay();
    checks++;
    if (o_queue_start !== 1'b1 || o_queue_data_valid !== 1'b0 || o_replay_done !== 1'b0) begin
      errors++; $display("FAIL zero_start: start %b valid %b done %b expected 1/0/0",
        o_queue_start, o_queue_data_valid, o_replay_done);
    end
    tick();
    checks++;
    if (o_replay_done !== 1'b1 || o_queue_data_valid !== 1'b0 || o_queue_start !== 1'b0) begin
      errors++; $display("FAIL zero_done: done %b valid %b start %b expected 1/0/0",
        o_replay_done, o_queue_data_valid, o_queue_start);
    end
  endtask

  task automatic test_valid_end_coincide();
    pulse_start();
    send_byte(8'h44);
    i_data = 8'h55; i_data_valid = 1'b1; i_data_end = 1'b1;
    tick();
    i_data_valid = 1'b0; i_data_end = 1'b0;
    checks++;
    if (o_frame_length !== 9'd2 || o_frame_ready !== 1'b1) begin
      errors++; $display("FAIL coincide_len: len %0d ready %b expected 2/1", o_frame_length, o_frame_ready);
    end
    i_queue_ready = 1'b1;
    pulse_replay();
    tick();
    checks++;
    if (o_queue_data_valid !== 1'b1 || o_queue_data !== 8'h44) begin
      errors++; $display("FAIL coincide_byte0: valid %b data %h expected 1/44", o_queue_data_valid, o_queue_data);
    end
    tick();
    checks++;
    if (o_queue_data_valid !== 1'b1 || o_queue_data !== 8'h55) begin
      errors++; $display("FAIL coincide_byte1: valid %b data %h expected 1/55", o_queue_data_valid, o_queue_data);
    end
    tick();
    checks++;
    if (o_replay_done !== 1'b1) begin
      errors++; $display("FAIL coincide_done: got %b expected 1", o_replay_done);
    end
  endtask

  task automatic test_overflow();
    pulse_start();
    for (int i = 0; i < 256; i++) send_byte(8'(i));
    checks++;
    if (o_overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_at_depth: got %b expected 0", o_overflow);
    end
    send_byte(8'hFF);
    checks++;
    if (o_overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_set: got %b expected 1", o_overflow);
    end
    pulse_end();
    checks++;
    if (o_overflow !== 1'b1 || o_frame_ready !== 1'b0) begin
      errors++; $display("FAIL ovf_after_end: ovf %b ready %b expected 1/0", o_overflow, o_frame_ready);
    end
    i_queue_ready = 1'b1;
    pulse_replay();
    checks++;
    if (o_queue_start !== 1'b0) begin
      errors++; $display("FAIL ovf_replay_ignored: start %b expected 0", o_queue_start);
    end
    tick();
    checks++;
    if (o_queue_data_valid !== 1'b0 || o_replay_done !== 1'b0) begin
      errors++; $display("FAIL ovf_no_data: valid %b done %b expected 0/0", o_queue_data_valid, o_replay_done);
    end
  endtask

  initial begin
    rst = 1'b1;
    i_data = 8'h00;
    i_data_start = 1'b0; i_data_valid = 1'b0; i_data_end = 1'b0;
    i_queue_locked = 1'b0; i_replay_start = 1'b0; i_queue_ready = 1'b0;
    test_reset();
    test_basic();
    test_ready_toggle();
    test_locked();
    test_reset_mid_replay();
    test_zero_length();
    test_valid_end_coincide();
    test_overflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
